pacman_collision: RTL and testbench

//  Downstream consumer of the monster position stage. Once per frame tick, steps the

---
 rtl/pacman_pkg.sv | 21 ++
 rtl/pacman_overlap.sv | 31 +++
 rtl/pacman_collision.sv | 142 ++++++++++++++
 tb/tb_pacman_collision.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and widths for the Pacman collision stage and its helpers.
package pacman_pkg;

    localparam int unsigned COORD_W = 9;
    localparam int unsigned IDX_W   = 3;

    // Collision FSM state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DEATH = 2'd2,
        OVER  = 2'd3
    } state_t;

    // A screen position in pixels
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

endpackage

// File: rtl/pacman_overlap.sv
// Combinational overlap test: both |px-mx| and |py-my| below HIT_DIST.
// Differences are taken one bit wider than the coordinates so they never wrap.
module pacman_overlap
    import pacman_pkg::*;
#(
    parameter int unsigned HIT_DIST = 8
) (
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] mx,
    input  logic [COORD_W-1:0] my,
    output logic               hit_now
);

    localparam int unsigned DW = COORD_W + 1;

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic        [DW-1:0] adx;
    logic        [DW-1:0] ady;

    // Signed differences, absolute values and threshold compare
    always_comb begin
        dx      = $signed({1'b0, px}) - $signed({1'b0, mx});
        dy      = $signed({1'b0, py}) - $signed({1'b0, my});
        adx     = dx[DW-1] ? DW'(-dx) : DW'(dx);
        ady     = dy[DW-1] ? DW'(-dy) : DW'(dy);
        hit_now = (adx < DW'(HIT_DIST)) && (ady < DW'(HIT_DIST));
    end

endmodule

// File: rtl/pacman_collision.sv
// Per-frame ghost scan against Pacman; owns lives, death/respawn timing and game-over.
// index is presented to the monster stage, whose m_x/m_y answer one cycle later, so
// the compare runs against a one-cycle delayed copy of index.
module pacman_collision
    import pacman_pkg::*;
#(
    parameter int unsigned N_MON        = 4,
    parameter int unsigned HIT_DIST     = 8,
    parameter int unsigned INIT_LIVES   = 3,
    parameter int unsigned DEATH_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [COORD_W-1:0] p_x,
    input  logic [COORD_W-1:0] p_y,
    input  logic [COORD_W-1:0] m_x,
    input  logic [COORD_W-1:0] m_y,
    output logic [IDX_W-1:0]   index,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_index,
    output logic               respawn,
    output logic [2:0]         lives,
    output logic               game_over,
    output logic               busy
);

    localparam int unsigned DC_W = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MON - 1);
    localparam logic [DC_W-1:0]  LAST_DC  = DC_W'(DEATH_CYCLES - 1);

    state_t            state;
    pos_t              pos_r;      // Pacman position latched at scan start
    logic              issuing;    // index still stepping through monsters
    logic              valid_d;    // m_x/m_y this cycle belong to idx_d
    logic [IDX_W-1:0]  idx_d;
    logic [DC_W-1:0]   death_cnt;
    logic              hit_now;

    pacman_overlap #(
        .HIT_DIST (HIT_DIST)
    ) u_overlap (
        .px      (pos_r.x),
        .py      (pos_r.y),
        .mx      (m_x),
        .my      (m_y),
        .hit_now (hit_now)
    );

    // Scan/death FSM with index pipeline, lives counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos_r     <= '0;
            issuing   <= 1'b0;
            valid_d   <= 1'b0;
            idx_d     <= '0;
            death_cnt <= '0;
            index     <= '0;
            hit       <= 1'b0;
            hit_index <= '0;
            respawn   <= 1'b0;
            lives     <= 3'(INIT_LIVES);
            game_over <= 1'b0;
            busy      <= 1'b0;
        end else begin
            hit     <= 1'b0;
            respawn <= 1'b0;
            case (state)
                IDLE: begin
                    issuing <= 1'b0;
                    valid_d <= 1'b0;
                    if (tick) begin
                        state   <= SCAN;
                        busy    <= 1'b1;
                        index   <= '0;
                        issuing <= 1'b1;
                        pos_r.x <= p_x;
                        pos_r.y <= p_y;
                    end
                end

                SCAN: begin
                    valid_d <= issuing;
                    idx_d   <= index;
                    if (issuing) begin
                        if (index == LAST_IDX) begin
                            issuing <= 1'b0;
                        end else begin
                            index <= index + 3'd1;
                        end
                    end
                    if (valid_d && hit_now) begin
                        // First hit ends the scan; later monsters are not looked at
                        hit       <= 1'b1;
                        hit_index <= idx_d;
                        lives     <= lives - 3'd1;
                        index     <= '0;
                        issuing   <= 1'b0;
                        valid_d   <= 1'b0;
                        death_cnt <= '0;
                        if (lives == 3'd1) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= DEATH;
                        end
                    end else if (valid_d && (idx_d == LAST_IDX)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        index   <= '0;
                        issuing <= 1'b0;
                        valid_d <= 1'b0;
                    end
                end

                DEATH: begin
                    if (death_cnt == LAST_DC) begin
                        respawn   <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        death_cnt <= '0;
                    end else begin
                        death_cnt <= death_cnt + DC_W'(1);
                    end
                end

                OVER: begin
                    index     <= '0;
                    game_over <= 1'b1;
                    busy      <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_collision.sv
// Self-checking bench for pacman_collision with a registered monster-position model.
module tb_pacman_collision;

    localparam int N_MON        = 4;
    localparam int HIT_DIST     = 8;
    localparam int INIT_LIVES   = 3;
    localparam int DEATH_CYCLES = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [8:0] p_x, p_y, m_x, m_y;
    logic [2:0] index, hit_index, lives;
    logic       hit, respawn, game_over, busy;

    int total = 0;
    int bad   = 0;

    // Reference state
    int mon_x [8];
    int mon_y [8];
    int mdl_lives;
    int mdl_hidx;
    int mdl_go;

    pacman_collision #(
        .N_MON        (N_MON),
        .HIT_DIST     (HIT_DIST),
        .INIT_LIVES   (INIT_LIVES),
        .DEATH_CYCLES (DEATH_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .p_x       (p_x),
        .p_y       (p_y),
        .m_x       (m_x),
        .m_y       (m_y),
        .index     (index),
        .hit       (hit),
        .hit_index (hit_index),
        .respawn   (respawn),
        .lives     (lives),
        .game_over (game_over),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monster stage: answers the index it saw on the previous cycle
    always @(posedge clk) begin
        m_x <= 9'(mon_x[index]);
        m_y <= 9'(mon_y[index]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // First scanned monster within HIT_DIST on both axes, or -1
    function automatic int first_hit(input int px, input int py);
        int dx, dy;
        for (int k = 0; k < N_MON; k++) begin
            dx = px - mon_x[k];
            dy = py - mon_y[k];
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            if (dx < HIT_DIST && dy < HIT_DIST) return k;
        end
        return -1;
    endfunction

    task automatic place_all(input int x, input int y);
        for (int k = 0; k < 8; k++) begin
            mon_x[k] = x;
            mon_y[k] = y;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mdl_lives = INIT_LIVES;
        mdl_hidx  = 0;
        mdl_go    = 0;
        chk("rst_lives", 32'(lives), 32'(INIT_LIVES));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_game_over", 32'(game_over), 32'(0));
    endtask

    // One tick-started scan; cycle c counts from the edge that samples tick.
    // Monster k reaches the comparator at c=k+1, so its hit is registered at c=k+2.
    task automatic do_scan(input int px, input int py, input bit noise);
        int k, c_hit, c_end, lives_after, el, ehi;
        logic eh, er, eb, ego;
        k = first_hit(px, py);
        c_hit = k + 2;
        lives_after = (k >= 0) ? mdl_lives - 1 : mdl_lives;
        if (k < 0)                 c_end = N_MON + 1;
        else if (lives_after == 0) c_end = c_hit + DEATH_CYCLES + 6;
        else                       c_end = c_hit + DEATH_CYCLES;
        @(negedge clk);
        p_x  = 9'(px);
        p_y  = 9'(py);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int c = 0; c <= c_end; c++) begin
            eh  = (k >= 0 && c == c_hit);
            er  = (k >= 0 && lives_after > 0 && c == c_end);
            eb  = (k >= 0 && lives_after == 0) ? 1'b1 : (c < c_end);
            el  = (k >= 0 && c >= c_hit) ? lives_after : mdl_lives;
            ehi = (k >= 0 && c >= c_hit) ? k : mdl_hidx;
            ego = (mdl_go != 0) || (k >= 0 && lives_after == 0 && c >= c_hit);
            chk("hit", 32'(hit), 32'(eh));
            chk("respawn", 32'(respawn), 32'(er));
            chk("busy", 32'(busy), 32'(eb));
            chk("lives", 32'(lives), 32'(el));
            chk("hit_index", 32'(hit_index), 32'(ehi));
            chk("game_over", 32'(game_over), 32'(ego));
            if (c < N_MON && (k < 0 || c < c_hit)) chk("index_step", 32'(index), 32'(c));
            if (noise) begin
                p_x = 9'($urandom);
                p_y = 9'($urandom);
            end
            tick = (noise && c < c_end) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        tick = 1'b0;
        if (k >= 0) begin
            mdl_lives = lives_after;
            mdl_hidx  = k;
            if (lives_after == 0) mdl_go = 1;
        end
        // No scan may have been queued by ticks seen while busy
        chk("after_busy", 32'(busy), 32'(mdl_go != 0));
        chk("after_hit", 32'(hit), 32'(0));
        chk("after_index", 32'(index), 32'(0));
    endtask

    // Start a scan that would hit monster 2, then reset at cycle at_c
    task automatic rst_mid(input int at_c);
        @(negedge clk);
        p_x  = 9'(55);
        p_y  = 9'(66);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (at_c) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_lives = INIT_LIVES;
        mdl_hidx  = 0;
        mdl_go    = 0;
        for (int c = 0; c < 80; c++) begin
            chk("rm_hit", 32'(hit), 32'(0));
            chk("rm_respawn", 32'(respawn), 32'(0));
            chk("rm_busy", 32'(busy), 32'(0));
            chk("rm_lives", 32'(lives), 32'(INIT_LIVES));
            @(negedge clk);
        end
    endtask

    initial begin
        int px, py;
        rst  = 1'b1;
        tick = 1'b0;
        p_x  = '0;
        p_y  = '0;
        place_all(100, 100);
        repeat (2) @(negedge clk);
        chk("reset_index", 32'(index), 32'(0));
        chk("reset_hit", 32'(hit), 32'(0));
        chk("reset_hit_index", 32'(hit_index), 32'(0));
        chk("reset_respawn", 32'(respawn), 32'(0));
        chk("reset_lives", 32'(lives), 32'(INIT_LIVES));
        chk("reset_game_over", 32'(game_over), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        mdl_lives = INIT_LIVES;
        mdl_hidx  = 0;
        mdl_go    = 0;

        // Clear scan, then a hit on monster 2 with full death sequence
        do_scan(10, 10, 1'b0);
        mon_x[2] = 50;
        mon_y[2] = 60;
        do_scan(55, 66, 1'b0);

        // Threshold boundary and no-wrap subtraction
        do_reset();
        place_all(300, 300);
        mon_x[0] = 40;
        mon_y[0] = 40;
        do_scan(48, 40, 1'b0);
        do_scan(47, 47, 1'b0);
        mon_x[0] = 7;
        mon_y[0] = 0;
        do_scan(0, 0, 1'b0);

        // Two overlapping monsters: only the first scanned one counts
        do_reset();
        place_all(300, 300);
        mon_x[1] = 200;
        mon_y[1] = 200;
        mon_x[3] = 202;
        mon_y[3] = 205;
        do_scan(200, 200, 1'b1);

        // Three hits to game over; ticks ignored afterwards until reset
        do_reset();
        place_all(300, 300);
        mon_x[0] = 100;
        mon_y[0] = 100;
        do_scan(100, 100, 1'b1);
        do_scan(100, 100, 1'b1);
        do_scan(100, 100, 1'b1);
        for (int c = 0; c < 20; c++) begin
            chk("over_busy", 32'(busy), 32'(1));
            chk("over_hit", 32'(hit), 32'(0));
            chk("over_respawn", 32'(respawn), 32'(0));
            chk("over_lives", 32'(lives), 32'(0));
            chk("over_index", 32'(index), 32'(0));
            chk("over_game_over", 32'(game_over), 32'(1));
            tick = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        tick = 1'b0;
        do_reset();

        // Reset mid-scan (on the would-be hit edge) and mid-death
        place_all(100, 100);
        mon_x[2] = 50;
        mon_y[2] = 60;
        rst_mid(3);
        rst_mid(30);

        // Randomized scans with monsters clustered near Pacman
        do_reset();
        for (int n = 0; n < 24; n++) begin
            px = int'($urandom_range(20, 490));
            py = int'($urandom_range(20, 490));
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    mon_x[k] = px + int'($urandom_range(0, 20)) - 10;
                    mon_y[k] = py + int'($urandom_range(0, 20)) - 10;
                end else begin
                    mon_x[k] = int'($urandom_range(0, 511));
                    mon_y[k] = int'($urandom_range(0, 511));
                end
            end
            do_scan(px, py, 1'b1);
            if (mdl_go != 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
